fft_stage_iter: RTL and testbench

Iterative, parametrised radix-2 DIT FFT stage that accepts one flattened complex frame, runs the butterflies for a runtime-selected stage over multiple cycles on a configurable number of butterfly units, and returns the frame in place. It replaces the fixed, single-stage-per-instance FFT stage. A single instance can now sequence every stage of an N-point transform, trading area against latency via `N_BFLY`.

---
 rtl/fft_pkg.sv | 53 +++++
 rtl/fft_butterfly.sv | 43 ++++
 rtl/fft_stage_iter.sv | 213 +++++++++++++++++++++
 tb/tb_fft_stage_iter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, state encoding and fixed-point helpers for the iterative FFT stage.
package fft_pkg;

  localparam int BW_MAX         = 64;
  localparam int DEF_BIT_WIDTH  = 32;
  localparam int DEF_DECIMAL_PT = 16;
  localparam int DEF_N_SAMPLES  = 8;
  localparam int DEF_N_BFLY     = 1;

  // Words are carried sign-extended to BW_MAX bits; only the low BIT_WIDTH
  // bits are meaningful, so wrap-around arithmetic is preserved.
  typedef logic signed [BW_MAX-1:0] word_t;

  typedef struct packed {
    word_t re;
    word_t im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time constants.
  function automatic int log2_n(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Cycles spent in COMPUTE for one stage.
  function automatic int n_iter(input int n, input int nb);
    return n / (2 * nb);
  endfunction

  // Counter width, never below one bit even when a stage takes a single cycle.
  function automatic int cnt_width(input int iters);
    return (iters > 1) ? log2_n(iters) : 1;
  endfunction

  // Full-precision signed product, arithmetically shifted right by dp
  // (truncation toward minus infinity). Caller keeps the low word bits.
  function automatic word_t fx_mul(input word_t a, input word_t b, input int dp);
    logic signed [2*BW_MAX-1:0] prod;
    prod = (2*BW_MAX)'(a) * (2*BW_MAX)'(b);
    return word_t'(prod >>> dp);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: X_i = A + W*B, X_j = A - W*B with W = cos - j*sin.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int DECIMAL_PT = DEF_DECIMAL_PT
) (
  input  logic [BIT_WIDTH-1:0] a_re,
  input  logic [BIT_WIDTH-1:0] a_im,
  input  logic [BIT_WIDTH-1:0] b_re,
  input  logic [BIT_WIDTH-1:0] b_im,
  input  logic [BIT_WIDTH-1:0] cos_w,
  input  logic [BIT_WIDTH-1:0] sin_w,
  output logic [BIT_WIDTH-1:0] xi_re,
  output logic [BIT_WIDTH-1:0] xi_im,
  output logic [BIT_WIDTH-1:0] xj_re,
  output logic [BIT_WIDTH-1:0] xj_im
);

  cplx_t a;
  cplx_t b;
  cplx_t wb;
  word_t c;
  word_t s;

  // Sign-extend operands and form the twiddled B; each product is truncated before summing.
  always_comb begin
    a.re  = word_t'(signed'(a_re));
    a.im  = word_t'(signed'(a_im));
    b.re  = word_t'(signed'(b_re));
    b.im  = word_t'(signed'(b_im));
    c     = word_t'(signed'(cos_w));
    s     = word_t'(signed'(sin_w));
    wb.re = fx_mul(b.re, c, DECIMAL_PT) + fx_mul(b.im, s, DECIMAL_PT);
    wb.im = fx_mul(b.im, c, DECIMAL_PT) - fx_mul(b.re, s, DECIMAL_PT);
  end

  assign xi_re = BIT_WIDTH'(a.re + wb.re);
  assign xi_im = BIT_WIDTH'(a.im + wb.im);
  assign xj_re = BIT_WIDTH'(a.re - wb.re);
  assign xj_im = BIT_WIDTH'(a.im - wb.im);

endmodule

// File: rtl/fft_stage_iter.sv
// Iterative radix-2 DIT FFT stage: latches a frame, runs the selected stage in place
// over N_SAMPLES/(2*N_BFLY) cycles using N_BFLY butterflies, then presents the frame.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | ready for a frame; recv_rdy high
// ST_COMPUTE | butterflies c*N_BFLY .. c*N_BFLY+N_BFLY-1 written back each cycle
// ST_DONE    | send_val high, buffer held until send_rdy
module fft_stage_iter
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int DECIMAL_PT = DEF_DECIMAL_PT,
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int N_BFLY     = DEF_N_BFLY
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2*BIT_WIDTH*N_SAMPLES-1:0]   recv_msg,
  input  logic [$clog2(N_SAMPLES)-1:0]       recv_stage,
  input  logic                               recv_val,
  output logic                               recv_rdy,
  output logic [2*BIT_WIDTH*N_SAMPLES-1:0]   send_msg,
  output logic                               send_val,
  input  logic                               send_rdy,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0]     sine_wave_out
);

  localparam int LOG2N  = log2_n(N_SAMPLES);
  localparam int SW     = $clog2(N_SAMPLES);
  localparam int IW     = LOG2N;
  localparam int N_ITER = n_iter(N_SAMPLES, N_BFLY);
  localparam int CW     = cnt_width(N_ITER);

  state_t               state_q;
  state_t               state_d;
  logic [SW-1:0]        stage_q;
  logic [SW-1:0]        stage_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  logic [BIT_WIDTH-1:0] buf_re_q [N_SAMPLES];
  logic [BIT_WIDTH-1:0] buf_im_q [N_SAMPLES];
  logic [BIT_WIDTH-1:0] buf_re_d [N_SAMPLES];
  logic [BIT_WIDTH-1:0] buf_im_d [N_SAMPLES];
  logic [BIT_WIDTH-1:0] sin_tab  [N_SAMPLES];

  logic                 accept;
  logic                 last_iter;
  logic [IW-1:0]        half;
  logic [IW-1:0]        mask;
  logic [SW-1:0]        t_shift;

  logic [IW-1:0]        i_idx [N_BFLY];
  logic [IW-1:0]        j_idx [N_BFLY];
  logic [BIT_WIDTH-1:0] a_re  [N_BFLY];
  logic [BIT_WIDTH-1:0] a_im  [N_BFLY];
  logic [BIT_WIDTH-1:0] b_re  [N_BFLY];
  logic [BIT_WIDTH-1:0] b_im  [N_BFLY];
  logic [BIT_WIDTH-1:0] cos_w [N_BFLY];
  logic [BIT_WIDTH-1:0] sin_w [N_BFLY];
  logic [BIT_WIDTH-1:0] xi_re [N_BFLY];
  logic [BIT_WIDTH-1:0] xi_im [N_BFLY];
  logic [BIT_WIDTH-1:0] xj_re [N_BFLY];
  logic [BIT_WIDTH-1:0] xj_im [N_BFLY];

  // Handshake outputs are gated by reset so they drop the moment reset asserts.
  assign recv_rdy  = (state_q == ST_IDLE) && reset;
  assign send_val  = (state_q == ST_DONE) && reset;
  assign accept    = recv_val && recv_rdy;
  assign last_iter = (cnt_q == CW'(N_ITER - 1));

  // State, stored stage and butterfly counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; stages at or beyond log2(N) bypass straight to DONE.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stage_d = recv_stage;
          cnt_d   = '0;
          state_d = (int'(recv_stage) < LOG2N) ? ST_COMPUTE : ST_DONE;
        end
      end
      ST_COMPUTE: begin
        if (last_iter) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (send_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Unpack the sine table supplied by the caller.
  always_comb begin
    for (int k = 0; k < N_SAMPLES; k++) begin
      sin_tab[k] = sine_wave_out[BIT_WIDTH*k +: BIT_WIDTH];
    end
  end

  // Operand and twiddle selection for the butterflies active this cycle.
  // i = b + (b & ~(half-1)) is (b/half)*2*half + pos; j sets the half bit,
  // which is always clear in i.
  always_comb begin
    logic [IW-1:0] b_idx;
    logic [IW-1:0] t_idx;
    b_idx   = '0;
    t_idx   = '0;
    half    = IW'(1) << stage_q;
    mask    = half - IW'(1);
    t_shift = SW'(LOG2N - 1) - stage_q;
    for (int k = 0; k < N_BFLY; k++) begin
      b_idx    = IW'(int'(cnt_q) * N_BFLY + k);
      i_idx[k] = b_idx + (b_idx & ~mask);
      j_idx[k] = i_idx[k] | half;
      t_idx    = (b_idx & mask) << t_shift;
      cos_w[k] = sin_tab[t_idx + IW'(N_SAMPLES / 4)];
      sin_w[k] = sin_tab[t_idx];
      a_re[k]  = buf_re_q[i_idx[k]];
      a_im[k]  = buf_im_q[i_idx[k]];
      b_re[k]  = buf_re_q[j_idx[k]];
      b_im[k]  = buf_im_q[j_idx[k]];
    end
  end

  for (genvar g = 0; g < N_BFLY; g++) begin : g_bfly
    fft_butterfly #(
      .BIT_WIDTH  (BIT_WIDTH),
      .DECIMAL_PT (DECIMAL_PT)
    ) u_bfly (
      .a_re  (a_re[g]),
      .a_im  (a_im[g]),
      .b_re  (b_re[g]),
      .b_im  (b_im[g]),
      .cos_w (cos_w[g]),
      .sin_w (sin_w[g]),
      .xi_re (xi_re[g]),
      .xi_im (xi_im[g]),
      .xj_re (xj_re[g]),
      .xj_im (xj_im[g])
    );
  end

  // Buffer next value: load on accept, in-place write-back while computing.
  always_comb begin
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          for (int k = 0; k < N_SAMPLES; k++) begin
            buf_re_d[k] = recv_msg[BIT_WIDTH*(N_SAMPLES+k) +: BIT_WIDTH];
            buf_im_d[k] = recv_msg[BIT_WIDTH*k +: BIT_WIDTH];
          end
        end
      end
      ST_COMPUTE: begin
        for (int k = 0; k < N_BFLY; k++) begin
          buf_re_d[i_idx[k]] = xi_re[k];
          buf_im_d[i_idx[k]] = xi_im[k];
          buf_re_d[j_idx[k]] = xj_re[k];
          buf_im_d[j_idx[k]] = xj_im[k];
        end
      end
      default: ;
    endcase
  end

  // Frame buffer registers, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        buf_re_q[k] <= '0;
        buf_im_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        buf_re_q[k] <= buf_re_d[k];
        buf_im_q[k] <= buf_im_d[k];
      end
    end
  end

  // Present the buffer in the flattened frame layout.
  always_comb begin
    send_msg = '0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      send_msg[BIT_WIDTH*(N_SAMPLES+k) +: BIT_WIDTH] = buf_re_q[k];
      send_msg[BIT_WIDTH*k +: BIT_WIDTH]             = buf_im_q[k];
    end
  end

endmodule

// File: tb/tb_fft_stage_iter.sv
// Directed bench for fft_stage_iter: N=8 with one butterfly, plus an N_BFLY=4 instance.
module tb_fft_stage_iter;

  localparam int BW = 32;
  localparam int N  = 8;
  localparam int FW = 2 * BW * N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [FW-1:0] recv_msg = '0;
  logic [2:0]    recv_stage = '0;
  logic          recv_val = 1'b0;
  logic          recv_val4 = 1'b0;
  logic          send_rdy = 1'b0;
  logic          send_rdy4 = 1'b0;
  logic          recv_rdy, recv_rdy4, send_val, send_val4;
  logic [FW-1:0] send_msg, send_msg4;
  logic [BW*N-1:0] sine_tab = '0;

  logic [31:0] sin_q16 [8] = '{32'h00000000, 32'h0000B505, 32'h00010000, 32'h0000B505,
                               32'h00000000, 32'hFFFF4AFB, 32'hFFFF0000, 32'hFFFF4AFB};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_stage_iter #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .N_BFLY(1)) dut (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_stage(recv_stage),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val),
    .send_rdy(send_rdy), .sine_wave_out(sine_tab)
  );

  fft_stage_iter #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .N_BFLY(4)) dut4 (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_stage(recv_stage),
    .recv_val(recv_val4), .recv_rdy(recv_rdy4), .send_msg(send_msg4), .send_val(send_val4),
    .send_rdy(send_rdy4), .sine_wave_out(sine_tab)
  );

  function automatic logic [FW-1:0] put(input logic [FW-1:0] f, input int k,
                                        input logic [31:0] re, input logic [31:0] im);
    logic [FW-1:0] r;
    r = f;
    r[BW*(N+k) +: BW] = re;
    r[BW*k +: BW]     = im;
    return r;
  endfunction

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one frame and count edges from the accepting edge until send_val rises.
  task automatic send_frame(input bit use4, input logic [2:0] stg, input logic [FW-1:0] f,
                            output int lat);
    @(negedge clk);
    recv_msg   = f;
    recv_stage = stg;
    if (use4) recv_val4 = 1'b1;
    else      recv_val  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      recv_val  = 1'b0;
      recv_val4 = 1'b0;
    end while (!(use4 ? send_val4 : send_val) && lat < 40);
  endtask

  task automatic drain(input bit use4);
    if (use4) send_rdy4 = 1'b1;
    else      send_rdy  = 1'b1;
    @(negedge clk);
    send_rdy  = 1'b0;
    send_rdy4 = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] f0, e0, f2, e2, ft, et, fw, ew, fb;
    int lat;

    for (int k = 0; k < N; k++) sine_tab[BW*k +: BW] = sin_q16[k];

    f0 = put(put('0, 0, 32'h00010000, 32'h0), 1, 32'h00010000, 32'h0);
    e0 = put('0, 0, 32'h00020000, 32'h0);
    f2 = put(put('0, 4, 32'h00010000, 32'h0), 5, 32'h00010000, 32'h0);
    e2 = put(put(put(put('0, 0, 32'h00010000, 32'h0), 4, 32'hFFFF0000, 32'h0),
                 1, 32'h0000B505, 32'hFFFF4AFB), 5, 32'hFFFF4AFB, 32'h0000B505);
    ft = put('0, 5, 32'hFFFFFFFF, 32'h0);
    et = put(put('0, 1, 32'hFFFFFFFF, 32'h00000001), 5, 32'h00000001, 32'hFFFFFFFF);
    fw = put(put(put('0, 0, 32'h7FFF0000, 32'h00030000), 1, 32'h00010000, 32'hFFFE0000),
             6, 32'h00000005, 32'h0);
    ew = put(put(put(put('0, 0, 32'h80000000, 32'h00010000), 1, 32'h7FFE0000, 32'h00050000),
                 6, 32'h00000005, 32'h0), 7, 32'h00000005, 32'h0);
    fb = '0;
    for (int k = 0; k < N; k++) fb = put(fb, k, 32'h13570000 + 32'(k), 32'hACE00000 | 32'(k));

    // Reset and idle
    repeat (3) @(negedge clk);
    check_v("rst_recv_rdy", int'(recv_rdy), 0);
    check_v("rst_send_val", int'(send_val), 0);
    check("rst_send_msg", send_msg, '0);
    reset = 1'b1;
    @(negedge clk);
    check_v("rel_recv_rdy", int'(recv_rdy), 1);

    // Stage 0, then backpressure while another frame is offered
    send_frame(1'b0, 3'd0, f0, lat);
    check_v("s0_latency", lat, 5);
    check("s0_data", send_msg, e0);
    recv_msg   = ~f0;
    recv_stage = 3'd3;
    recv_val   = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_msg_hold", send_msg, e0);
    check_v("bp_recv_rdy", int'(recv_rdy), 0);
    check_v("bp_send_val", int'(send_val), 1);
    recv_val = 1'b0;
    drain(1'b0);
    @(negedge clk);
    check_v("bp_idle_rdy", int'(recv_rdy), 1);
    check_v("bp_idle_val", int'(send_val), 0);
    check("bp_no_new_frame", send_msg, e0);

    // Stage 2 impulse pair
    send_frame(1'b0, 3'd2, f2, lat);
    check_v("s2_latency", lat, 5);
    check("s2_data", send_msg, e2);
    drain(1'b0);

    // Stage 2 truncation toward minus infinity
    send_frame(1'b0, 3'd2, ft, lat);
    check("s2_trunc_data", send_msg, et);
    drain(1'b0);

    // Stage 0 wrap-around and imaginary parts
    send_frame(1'b0, 3'd0, fw, lat);
    check("s0_wrap_data", send_msg, ew);
    drain(1'b0);

    // Bypass stage
    send_frame(1'b0, 3'd3, fb, lat);
    check_v("byp_latency", lat, 1);
    check("byp_data", send_msg, fb);
    drain(1'b0);

    // Reset asserted during COMPUTE
    recv_msg   = f0;
    recv_stage = 3'd0;
    recv_val   = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_v("rstc_send_val", int'(send_val), 0);
    check_v("rstc_recv_rdy", int'(recv_rdy), 0);
    check("rstc_msg_clear", send_msg, '0);
    @(negedge clk);
    reset = 1'b1;
    send_frame(1'b0, 3'd0, f0, lat);
    check_v("rstc_redo_latency", lat, 5);
    check("rstc_redo_data", send_msg, e0);

    // Reset asserted during DONE drops send_val asynchronously
    #2 reset = 1'b0;
    #1;
    check_v("rstd_send_val", int'(send_val), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_v("rstd_idle_rdy", int'(recv_rdy), 1);

    // Four butterflies per cycle
    send_frame(1'b1, 3'd0, f0, lat);
    check_v("nb4_s0_latency", lat, 2);
    check("nb4_s0_data", send_msg4, e0);
    drain(1'b1);
    send_frame(1'b1, 3'd2, f2, lat);
    check_v("nb4_s2_latency", lat, 2);
    check("nb4_s2_data", send_msg4, e2);
    drain(1'b1);
    check_v("nb4_idle_rdy", int'(recv_rdy4), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
